// File: rtl/pc_return_stack_if.sv
// rtl/pc_return_stack_if.sv - control-unit <-> return-stack signal bundle
//
// Purpose: groups the push/pop command signals driven by the control unit and
// the status/data signals returned by the return-address stack.
// Ports (signals):
//   push      control -> stack  store pc_count+1 on this edge
//   pop       control -> stack  discard top entry on this edge
//   clr_err   control -> stack  clear sticky overflow/underflow
//   pc_count  control -> stack  current PC value (AW bits)
//   data_out  stack -> control  top-of-stack return address (AW bits)
//   count     stack -> control  number of valid entries
//   empty     stack -> control  count == 0
//   full      stack -> control  count == DEPTH
//   overflow  stack -> control  sticky: push attempted while full
//   underflow stack -> control  sticky: pop attempted while empty
interface pc_return_stack_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 10
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic          clr_err;
  logic [AW-1:0] pc_count;
  logic [AW-1:0] data_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, clr_err, pc_count,
    input  data_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err, pc_count,
    output data_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - return-address stack feeding the PC input mux
//
// Purpose: on CALL/interrupt entry pushes pc_count+1; on RET/RETI pops. The
// top entry is presented combinationally on data_out so the PC can load it
// in the same cycle the pop is issued.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of pc_return_stack_if (push/pop/clr_err/pc_count in;
//         data_out/count/empty/full/overflow/underflow out)
module pc_return_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  pc_return_stack_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;

  logic          is_empty;
  logic          is_full;
  logic [AW-1:0] push_data;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic [CW-1:0] count_d;
  logic          ovf_event;
  logic          udf_event;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  // Natural AW-bit wrap: the last address returns to 0.
  assign push_data = bus.pc_count + AW'(1);
  assign top_idx   = IW'(count_q - CW'(1));

  // A push with a simultaneous pop overwrites the current top in place; on an
  // empty stack it degenerates into a plain push into slot 0.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = IW'(count_q);
    count_d   = count_q;
    ovf_event = 1'b0;
    udf_event = 1'b0;
    if (bus.push && bus.pop) begin
      wr_en = 1'b1;
      if (!is_empty) begin
        wr_idx = top_idx;
      end else begin
        wr_idx    = '0;
        count_d   = CW'(1);
        udf_event = 1'b1;
      end
    end else if (bus.push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        ovf_event = 1'b1;
      end
    end else if (bus.pop) begin
      if (!is_empty) begin
        count_d = count_q - CW'(1);
      end else begin
        udf_event = 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  // An error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (udf_event) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = is_empty ? '0 : mem[top_idx];
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// tb/tb_pc_return_stack.sv - directed scoreboard bench for pc_return_stack
module tb_pc_return_stack;
  localparam int DEPTH = 16;
  localparam int AW    = 10;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [AW-1:0] data;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ful;
    logic          ovf;
    logic          udf;
  } exp_t;

  logic clk;
  logic rst;

  pc_return_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  pc_return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t          sb[$];
  logic [AW-1:0] model[$];
  logic          m_ovf;
  logic          m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.data = (model.size() > 0) ? model[model.size()-1] : '0;
    e.cnt  = CW'(model.size());
    e.emp  = (model.size() == 0);
    e.ful  = (model.size() == DEPTH);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ":data_out"}, 32'(bus.data_out), 32'(e.data));
      check({tag, ":count"}, 32'(bus.count), 32'(e.cnt));
      check({tag, ":empty"}, 32'(bus.empty), 32'(e.emp));
      check({tag, ":full"}, 32'(bus.full), 32'(e.ful));
      check({tag, ":overflow"}, 32'(bus.overflow), 32'(e.ovf));
      check({tag, ":underflow"}, 32'(bus.underflow), 32'(e.udf));
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then sample 1ns
  // after the edge.
  task automatic step(input string tag, input logic pu, input logic po,
                      input logic clr, input logic [AW-1:0] pc);
    logic [AW-1:0] pd;
    logic ovf_ev;
    logic udf_ev;
    bus.push     = pu;
    bus.pop      = po;
    bus.clr_err  = clr;
    bus.pc_count = pc;
    pd     = pc + 10'd1;
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    if (pu && po) begin
      if (model.size() > 0) begin
        model[model.size()-1] = pd;
      end else begin
        model.push_back(pd);
        udf_ev = 1'b1;
      end
    end else if (pu) begin
      if (model.size() < DEPTH) model.push_back(pd);
      else ovf_ev = 1'b1;
    end else if (po) begin
      if (model.size() > 0) void'(model.pop_back());
      else udf_ev = 1'b1;
    end
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = udf_ev ? 1'b1 : (clr ? 1'b0 : m_udf);
    sb.push_back(model_state());
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    compare_outputs(tag);
  endtask

  initial begin
    rst          = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.clr_err  = 1'b0;
    bus.pc_count = '0;
    m_ovf        = 1'b0;
    m_udf        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset:count", 32'(bus.count), 32'd0);
    check("reset:empty", 32'(bus.empty), 32'd1);
    check("reset:full", 32'(bus.full), 32'd0);
    check("reset:data_out", 32'(bus.data_out), 32'd0);
    check("reset:overflow", 32'(bus.overflow), 32'd0);
    check("reset:underflow", 32'(bus.underflow), 32'd0);
    rst = 1'b0;

    // Single push
    step("t1_push", 1, 0, 0, 10'h020);
    check("t1_data", 32'(bus.data_out), 32'h021);
    step("t1_pop", 0, 1, 0, 10'h000);

    // Three pushes including wrap, then three pops
    step("t2_push010", 1, 0, 0, 10'h010);
    step("t2_push050", 1, 0, 0, 10'h050);
    step("t2_push3ff", 1, 0, 0, 10'h3FF);
    check("t2_wrap", 32'(bus.data_out), 32'h000);
    step("t2_pop1", 0, 1, 0, 10'h000);
    step("t2_pop2", 0, 1, 0, 10'h000);
    step("t2_pop3", 0, 1, 0, 10'h000);
    check("t2_empty", 32'(bus.empty), 32'd1);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      step("t3_fill", 1, 0, 0, AW'(10'h100 + i));
    end
    step("t3_ovf", 1, 0, 0, 10'h200);
    check("t3_top", 32'(bus.data_out), 32'h110);
    check("t3_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step("t3_drain", 0, 1, 0, 10'h000);
    end
    step("t3_clr", 0, 0, 1, 10'h000);

    // Underflow and clear priority
    step("t4_udf", 0, 1, 0, 10'h000);
    step("t4_clr", 0, 0, 1, 10'h000);
    step("t4_clr_vs_udf", 0, 1, 1, 10'h000);
    check("t4_udf_sticky", 32'(bus.underflow), 32'd1);
    step("t4_clr2", 0, 0, 1, 10'h000);

    // Simultaneous push and pop
    step("t5_push", 1, 0, 0, 10'h020);
    step("t5_push", 1, 0, 0, 10'h030);
    step("t5_replace", 1, 1, 0, 10'h07F);
    check("t5_replace_data", 32'(bus.data_out), 32'h080);
    step("t5_pop", 0, 1, 0, 10'h000);
    check("t5_below", 32'(bus.data_out), 32'h021);
    step("t5_pop", 0, 1, 0, 10'h000);
    step("t5_pp_empty", 1, 1, 0, 10'h1FF);

    // Asynchronous reset between edges
    step("t6_push", 1, 0, 0, 10'h040);
    step("t6_push", 1, 0, 0, 10'h041);
    check("t6_pre_count", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    model.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_data", 32'(bus.data_out), 32'd0);
    check("t6_rst_empty", 32'(bus.empty), 32'd1);
    check("t6_rst_udf", 32'(bus.underflow), 32'd0);
    check("t6_rst_ovf", 32'(bus.overflow), 32'd0);
    #1 rst = 1'b0;
    step("t6_after", 1, 0, 0, 10'h123);
    check("t6_after_count", 32'(bus.count), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
